// File: rtl/lsl_pipe_shifter.sv
// Pipelined logical left barrel shifter with valid/ready flow control and
// unsigned/signed left-shift overflow detection. One log-stage per amount bit,
// each followed by a register; stage SHW-1 drives the outputs directly.
module lsl_pipe_shifter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned NST = SHW;

  // Per-stage advance enables and the valid bits they depend on.
  logic [NST-1:0] adv_c;
  logic [NST-1:0] valid_vec;

  for (genvar k = 0; k < NST; k++) begin : g_stage
    localparam int unsigned S  = 1 << k;
    localparam int unsigned AW = SHW - k;

    // Fields entering this stage (from the inputs or the previous stage).
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [AW-1:0]    a_in;
    logic             s_in;
    logic             sg_in;
    logic             o_in;

    // Results of this stage's shift step and overflow accumulation.
    logic [WIDTH-1:0] d_nxt;
    logic             o_nxt;
    logic             lost_u;
    logic             lost_s;

    // Registered stage state that reaches the next stage or the outputs.
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;

    if (k == 0) begin : g_src
      assign v_in  = in_valid & in_ready;
      assign d_in  = in_data;
      assign a_in  = in_amount;
      assign s_in  = in_signed;
      assign sg_in = in_data[WIDTH-1];
      assign o_in  = 1'b0;
    end else begin : g_src
      assign v_in  = g_stage[k-1].valid_q;
      assign d_in  = g_stage[k-1].data_q;
      assign a_in  = g_stage[k-1].g_fwd.amt_q;
      assign s_in  = g_stage[k-1].g_fwd.signed_q;
      assign sg_in = g_stage[k-1].g_fwd.sign_q;
      assign o_in  = g_stage[k-1].ovf_q;
    end

    // Unsigned loses any set bit shifted out; signed also checks the new MSB.
    assign lost_u = |d_in[WIDTH-1 -: S];
    assign lost_s = (d_in[WIDTH-1 -: S+1] != {(S+1){sg_in}});
    assign d_nxt  = a_in[0] ? (d_in << S) : d_in;
    assign o_nxt  = o_in | (a_in[0] & (s_in ? lost_s : lost_u));

    assign valid_vec[k] = valid_q;
    assign adv_c[k]     = out_ready | ~(&valid_vec[NST-1:k]);

    // Stage register: load on advance, hold otherwise, clear on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        ovf_q   <= 1'b0;
      end else if (adv_c[k]) begin
        valid_q <= v_in;
        data_q  <= d_nxt;
        ovf_q   <= o_nxt;
      end
    end

    // Fields only needed by later stages: remaining amount bits and sign mode.
    if (k < NST - 1) begin : g_fwd
      logic [AW-2:0] amt_q;
      logic          signed_q;
      logic          sign_q;

      // Forward the unconsumed amount bits and the overflow-rule context.
      always_ff @(posedge clk) begin
        if (rst) begin
          amt_q    <= '0;
          signed_q <= 1'b0;
          sign_q   <= 1'b0;
        end else if (adv_c[k]) begin
          amt_q    <= a_in[AW-1:1];
          signed_q <= s_in;
          sign_q   <= sg_in;
        end
      end
    end
  end

  assign in_ready  = adv_c[0];
  assign out_valid = g_stage[NST-1].valid_q;
  assign out_data  = g_stage[NST-1].data_q;
  assign out_ovf   = g_stage[NST-1].ovf_q;

endmodule

// File: tb/tb_lsl_pipe_shifter.sv
// Randomized self-checking bench for lsl_pipe_shifter against a scoreboard
// fed by an arithmetic reference model.
module tb_lsl_pipe_shifter;

  localparam int unsigned W = 64;
  localparam int unsigned SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_amount;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] sb_q[$];

  lsl_pipe_shifter #(.WIDTH(W), .SHW(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amount(in_amount), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: result is a<<n; overflow iff shifting back does not recover a.
  function automatic logic [W:0] model(input logic [W-1:0] a, input int n, input bit s);
    logic [W-1:0] r;
    logic o;
    r = a << n;
    if (s) o = (($signed(r) >>> n) != $signed(a));
    else   o = ((r >> n) != a);
    return {o, r};
  endfunction

  // Monitor: push accepted beats, pop and compare delivered beats, check stall hold.
  logic [W:0] held;
  bit         stalled = 1'b0;
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      sb_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) check("stall_hold", {{(W-1){1'b0}}, out_ovf, out_data[0]} ^ {63'd0, held[W], held[0]} | {1'b0, out_data[W-1:1], 1'b0} , {1'b0, held[W-1:1], 1'b0});
      if (in_valid && in_ready) sb_q.push_back(model(in_data, int'(in_amount), in_signed));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", W'(out_valid), '0);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e[W-1:0]);
          check("out_ovf", W'(out_ovf), W'(e[W]));
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_ovf, out_data};
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] d, input int n, input bit s);
    in_valid  = v;
    in_data   = d;
    in_amount = SW'(n);
    in_signed = s;
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: d = d >> $urandom_range(0, 63);
      1: d = ~(~d >> $urandom_range(0, 63));
      default: ;
    endcase
    return d;
  endfunction

  // Single directed beat with latency measurement and explicit expected values.
  task automatic send_dir(input logic [W-1:0] a, input int n, input bit s,
                          input logic [W-1:0] exp_d, input bit exp_o, input string tag);
    int cnt;
    @(posedge clk); #1;
    drive(1'b1, a, n, s);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    drive(1'b0, '0, 0, 1'b0);
    cnt = 1;
    @(negedge clk);
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, W'(cnt), W'(6));
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_ovf"}, W'(out_ovf), W'(exp_o));
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", W'(out_ovf), '0);
    check("rst_in_ready", W'(in_ready), W'(1));

    send_dir(64'h0000_0000_0000_0001, 63, 1'b0, 64'h8000_0000_0000_0000, 1'b0, "basic");
    send_dir(64'h8000_0000_0000_0001, 1, 1'b0, 64'h0000_0000_0000_0002, 1'b1, "uovf");
    send_dir(64'h4000_0000_0000_0000, 1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, "sovf");
    send_dir(64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, "sneg");
    send_dir(64'hDEAD_BEEF_0123_4567, 0, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, "amt0");

    // Full-rate streaming: no bubbles in either direction.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      drive(1'b1, rnd_data(), $urandom_range(0, 63), 1'($urandom));
      out_ready = 1'b1;
      @(negedge clk);
      check("stream_in_ready", W'(in_ready), W'(1));
      if (i >= 6) check("stream_out_valid", W'(out_valid), W'(1));
    end
    @(posedge clk); #1 drive(1'b0, '0, 0, 1'b0);
    repeat (10) @(posedge clk);

    // Backpressure: exactly six beats fit before in_ready drops.
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive(1'b1, rnd_data(), $urandom_range(0, 63), 1'($urandom));
      out_ready = 1'b0;
      @(negedge clk);
      if (in_ready) acc++;
    end
    check("bp_accepts", W'(acc), W'(6));
    check("bp_in_ready", W'(in_ready), '0);

    // Random valid/ready toggling, then drain.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 3) != 0), rnd_data(), $urandom_range(0, 63), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    drive(1'b0, '0, 0, 1'b0);
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("drain_empty", W'(sb_q.size()), '0);
    check("drain_out_valid", W'(out_valid), '0);

    // Reset mid-flight: three in-flight beats must vanish.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, rnd_data() | 64'h1, $urandom_range(0, 63), 1'($urandom));
    end
    @(posedge clk); #1;
    drive(1'b0, '0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", W'(out_valid), '0);
    check("mrst_out_data", out_data, '0);
    check("mrst_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) acc++;
    end
    check("mrst_no_ghosts", W'(acc), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
